spi_storage_responder: RTL and testbench

SPI_STORAGE_RESPONDER -- requirements
Module: spi_storage_responder

---
 rtl/spi_storage_responder_if.sv | 25 ++
 rtl/spi_storage_responder.sv | 230 +++++++++++++++++++++++
 tb/tb_spi_storage_responder.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_storage_responder_if.sv
// Bundles the SPI pins and the word-wide backing-memory port of spi_storage_responder.
// The slave modport is the responder's view; master is the environment's view.
interface spi_storage_responder_if #(
  parameter int MEM_AW = 22
);
  logic              spi_cs_n;
  logic              spi_sck;
  logic              spi_mosi;
  logic              spi_miso;
  logic              mem_req;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  spi_cs_n, spi_sck, spi_mosi, mem_rdata,
    output spi_miso, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output spi_cs_n, spi_sck, spi_mosi, mem_rdata,
    input  spi_miso, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/spi_storage_responder.sv
// SPI mode-0 responder bridging 0x03 (read) / 0x02 (write) commands with a
// 24-bit byte address onto a 32-bit word memory port, with auto-incrementing bursts.
module spi_storage_responder #(
  parameter int SCK_MIN_DIV = 16,
  parameter int MEM_AW      = 22
) (
  input  logic                           clk,
  input  logic                           rst,
  spi_storage_responder_if.slave         bus,
  output logic                           busy,
  output logic                           cmd_err
);

  // Sync (3 clk) plus fetch (2 clk) plus the output flop must fit in one SCK half period.
  if (SCK_MIN_DIV < 12 || MEM_AW < 2 || MEM_AW > 22) begin : g_bad_params
    $error("spi_storage_responder: unsupported SCK_MIN_DIV or MEM_AW");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_FETCH  = 3'd3,
    S_READ   = 3'd4,
    S_WRITE  = 3'd5,
    S_IGNORE = 3'd6
  } state_t;

  localparam logic [MEM_AW-1:0] ADDR_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

  logic [2:0]        cs_sync_q, sck_sync_q;
  logic [1:0]        mosi_sync_q;
  state_t            state_q, state_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [31:0]       rx_q, rx_d;
  logic [31:0]       tx_q, tx_d;
  logic              is_read_q, is_read_d;
  logic              fetch_ph_q, fetch_ph_d;
  logic [MEM_AW-1:0] word_addr_q, word_addr_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              cmd_err_q, cmd_err_d;

  logic cs_rise_s, cs_fall_s, sck_rise_s, sck_fall_s, mosi_s;

  assign cs_rise_s  =  cs_sync_q[1]  & ~cs_sync_q[2];
  assign cs_fall_s  = ~cs_sync_q[1]  &  cs_sync_q[2];
  assign sck_rise_s =  sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall_s = ~sck_sync_q[1] &  sck_sync_q[2];
  assign mosi_s     =  mosi_sync_q[1];

  // Next-state, shifter and memory-port logic.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = 32'd0;
    is_read_d   = is_read_q;
    fetch_ph_d  = fetch_ph_q;
    word_addr_d = word_addr_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cmd_err_d   = 1'b0;

    if (cs_rise_s) begin
      // Deselect wins over any SCK edge seen in the same cycle.
      state_d   = S_IDLE;
      cmd_err_d = (state_q == S_WRITE) && (bit_cnt_q != 5'd0);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cs_fall_s) begin
            state_d   = S_CMD;
            bit_cnt_d = 5'd0;
          end else begin
            state_d   = S_IDLE;
          end
        end
        S_CMD: begin
          if (sck_rise_s) begin
            rx_d = {rx_q[30:0], mosi_s};
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = 5'd0;
              if ((rx_d[7:0] == 8'h03) || (rx_d[7:0] == 8'h02)) begin
                state_d   = S_ADDR;
                is_read_d = (rx_d[7:0] == 8'h03);
              end else begin
                state_d   = S_IGNORE;
                cmd_err_d = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end else begin
            rx_d = rx_q;
          end
        end
        S_ADDR: begin
          if (sck_rise_s) begin
            rx_d = {rx_q[30:0], mosi_s};
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d   = 5'd0;
              word_addr_d = rx_d[MEM_AW+1:2];
              if (is_read_q) begin
                state_d    = S_FETCH;
                fetch_ph_d = 1'b0;
                mem_req_d  = 1'b1;
                mem_addr_d = rx_d[MEM_AW+1:2];
              end else begin
                state_d    = S_WRITE;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end else begin
            rx_d = rx_q;
          end
        end
        S_FETCH: begin
          if (fetch_ph_q == 1'b0) begin
            fetch_ph_d = 1'b1;
          end else begin
            tx_d      = bus.mem_rdata;
            bit_cnt_d = 5'd0;
            state_d   = S_READ;
          end
        end
        S_READ: begin
          if (sck_rise_s) begin
            if (bit_cnt_q == 5'd31) begin
              state_d     = S_FETCH;
              fetch_ph_d  = 1'b0;
              bit_cnt_d   = 5'd0;
              word_addr_d = word_addr_q + ADDR_ONE;
              mem_req_d   = 1'b1;
              mem_addr_d  = word_addr_q + ADDR_ONE;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
              tx_d      = tx_q;
            end
          end else if (sck_fall_s && (bit_cnt_q != 5'd0)) begin
            // The fall right after a load keeps bit 31 on the line.
            tx_d = {tx_q[30:0], 1'b0};
          end else begin
            tx_d = tx_q;
          end
        end
        S_WRITE: begin
          if (sck_rise_s) begin
            rx_d = {rx_q[30:0], mosi_s};
            if (bit_cnt_q == 5'd31) begin
              bit_cnt_d   = 5'd0;
              mem_req_d   = 1'b1;
              mem_we_d    = 1'b1;
              mem_wdata_d = rx_d;
              mem_addr_d  = word_addr_q;
              word_addr_d = word_addr_q + ADDR_ONE;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end else begin
            rx_d = rx_q;
          end
        end
        S_IGNORE: begin
          state_d = S_IGNORE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // Synchronizers and all state / output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync_q   <= 3'd0;
      sck_sync_q  <= 3'd0;
      mosi_sync_q <= 2'd0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 5'd0;
      rx_q        <= 32'd0;
      tx_q        <= 32'd0;
      is_read_q   <= 1'b0;
      fetch_ph_q  <= 1'b0;
      word_addr_q <= {MEM_AW{1'b0}};
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {MEM_AW{1'b0}};
      mem_wdata_q <= 32'd0;
      busy_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[1:0], bus.spi_cs_n};
      sck_sync_q  <= {sck_sync_q[1:0], bus.spi_sck};
      mosi_sync_q <= {mosi_sync_q[0], bus.spi_mosi};
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      is_read_q   <= is_read_d;
      fetch_ph_q  <= fetch_ph_d;
      word_addr_q <= word_addr_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  // MISO is bit 31 of the transmit shifter, which is held at zero outside READ.
  assign bus.spi_miso  = tx_q[31];
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = busy_q;
  assign cmd_err       = cmd_err_q;

endmodule

// File: tb/tb_spi_storage_responder.sv
// Scoreboard bench for spi_storage_responder: expected memory accesses are queued
// as SPI stimulus is driven and compared as the responder issues mem_req.
module tb_spi_storage_responder;
  localparam int AW   = 22;
  localparam int HALF = 8;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } acc_t;

  logic clk;
  logic rst;
  logic busy;
  logic cmd_err;

  spi_storage_responder_if #(.MEM_AW(AW)) bus ();

  spi_storage_responder #(.SCK_MIN_DIV(16), .MEM_AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .busy    (busy),
    .cmd_err (cmd_err)
  );

  int          checks;
  int          errors;
  int          cmd_err_cnt;
  int          busy_low_cnt;
  int          base;
  acc_t        sb[$];
  logic [31:0] mem [int];
  logic [31:0] rx;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_acc(input logic we, input logic [AW-1:0] addr, input logic [31:0] wdata);
    acc_t e;
    e.we = we; e.addr = addr; e.wdata = wdata;
    sb.push_back(e);
  endtask

  // Memory model: read data is valid the cycle after a read strobe.
  always @(posedge clk) begin
    if (rst) begin
      bus.mem_rdata <= 32'd0;
    end else if (bus.mem_req && !bus.mem_we) begin
      bus.mem_rdata <= mem.exists(int'(bus.mem_addr)) ? mem[int'(bus.mem_addr)] : 32'h0BAD0BAD;
    end else if (bus.mem_req && bus.mem_we) begin
      mem[int'(bus.mem_addr)] = bus.mem_wdata;
    end
  end

  // Access monitor: each strobe must match the oldest expected access.
  always @(negedge clk) begin
    if (!rst && bus.mem_req) begin
      if (sb.size() == 0) begin
        chk("unexpected_req", {63'd0, bus.mem_req}, 64'd0);
      end else begin
        acc_t e;
        e = sb.pop_front();
        chk("acc_we", {63'd0, bus.mem_we}, {63'd0, e.we});
        chk("acc_addr", {42'd0, bus.mem_addr}, {42'd0, e.addr});
        if (e.we) chk("acc_wdata", {32'd0, bus.mem_wdata}, {32'd0, e.wdata});
      end
    end
    if (!rst && cmd_err) cmd_err_cnt++;
  end

  task automatic spi_start();
    bus.spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_stop();
    repeat (HALF) @(negedge clk);
    bus.spi_cs_n = 1'b1;
    repeat (4 * HALF) @(negedge clk);
  endtask

  // Mode-0 bits, MSB first; MISO is captured just before each rise. With
  // cs_on_last the chip select rises together with the final SCK rise.
  task automatic spi_bits(input logic [31:0] val, input int n, input logic cs_on_last,
                          output logic [31:0] got);
    got = 32'd0;
    for (int i = 0; i < n; i++) begin
      bus.spi_mosi = val[n-1-i];
      repeat (HALF) @(negedge clk);
      got = {got[30:0], bus.spi_miso};
      if (!busy) busy_low_cnt++;
      bus.spi_sck = 1'b1;
      if (cs_on_last && (i == n - 1)) bus.spi_cs_n = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.spi_sck = 1'b0;
    end
  endtask

  initial begin
    checks = 0; errors = 0; cmd_err_cnt = 0; busy_low_cnt = 0;
    rst = 1'b1;
    bus.spi_cs_n = 1'b1; bus.spi_sck = 1'b0; bus.spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_miso", {63'd0, bus.spi_miso}, 64'd0);
    chk("rst_req", {63'd0, bus.mem_req}, 64'd0);
    chk("rst_we", {63'd0, bus.mem_we}, 64'd0);
    chk("rst_addr", {42'd0, bus.mem_addr}, 64'd0);
    chk("rst_wdata", {32'd0, bus.mem_wdata}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_cmd_err", {63'd0, cmd_err}, 64'd0);
    rst = 1'b0;
    repeat (4 * HALF) @(negedge clk);

    // Single read of word 4.
    mem[4] = 32'hDEADBEEF;
    push_acc(1'b0, 22'd4, 32'd0);
    base = cmd_err_cnt; busy_low_cnt = 0;
    spi_start();
    spi_bits(32'h03, 8, 1'b0, rx);
    chk("cmd_miso", {32'd0, rx}, 64'd0);
    spi_bits(32'h000010, 24, 1'b0, rx);
    spi_bits(32'h0, 32, 1'b1, rx);
    chk("rd_data", {32'd0, rx}, {32'd0, 32'hDEADBEEF});
    chk("rd_busy_low", busy_low_cnt, 64'd0);
    repeat (4 * HALF) @(negedge clk);
    chk("rd_idle", {63'd0, busy}, 64'd0);
    chk("rd_sb", sb.size(), 64'd0);
    chk("rd_err", cmd_err_cnt - base, 64'd0);

    // Burst read wrapping from the top word to word 0.
    mem[22'h3FFFFF] = 32'hA5A51234;
    mem[0] = 32'h0F0FC3C3;
    push_acc(1'b0, 22'h3FFFFF, 32'd0);
    push_acc(1'b0, 22'h0, 32'd0);
    spi_start();
    spi_bits(32'h03, 8, 1'b0, rx);
    spi_bits(32'hFFFFFC, 24, 1'b0, rx);
    spi_bits(32'h0, 32, 1'b0, rx);
    chk("burst_w0", {32'd0, rx}, {32'd0, 32'hA5A51234});
    spi_bits(32'h0, 32, 1'b1, rx);
    chk("burst_w1", {32'd0, rx}, {32'd0, 32'h0F0FC3C3});
    repeat (4 * HALF) @(negedge clk);
    chk("burst_sb", sb.size(), 64'd0);

    // Two-word write at byte address 0x20.
    push_acc(1'b1, 22'd8, 32'h12345678);
    push_acc(1'b1, 22'd9, 32'h9ABCDEF0);
    base = cmd_err_cnt;
    spi_start();
    spi_bits(32'h02, 8, 1'b0, rx);
    spi_bits(32'h000020, 24, 1'b0, rx);
    spi_bits(32'h12345678, 32, 1'b0, rx);
    spi_bits(32'h9ABCDEF0, 32, 1'b0, rx);
    spi_stop();
    chk("wr_sb", sb.size(), 64'd0);
    chk("wr_err", cmd_err_cnt - base, 64'd0);

    // Truncated write: 20 data bits then deselect.
    base = cmd_err_cnt;
    spi_start();
    spi_bits(32'h02, 8, 1'b0, rx);
    spi_bits(32'h000000, 24, 1'b0, rx);
    spi_bits(32'hABCDE, 20, 1'b0, rx);
    repeat (HALF) @(negedge clk);
    bus.spi_cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("trunc_busy", {63'd0, busy}, 64'd0);
    repeat (4 * HALF) @(negedge clk);
    chk("trunc_err", cmd_err_cnt - base, 64'd1);
    chk("trunc_sb", sb.size(), 64'd0);

    // Unsupported opcode then 40 more clocks.
    base = cmd_err_cnt;
    spi_start();
    spi_bits(32'h9F, 8, 1'b0, rx);
    chk("bad_err_after8", cmd_err_cnt - base, 64'd1);
    spi_bits(32'hFFFFFFFF, 32, 1'b0, rx);
    chk("bad_miso32", {32'd0, rx}, 64'd0);
    spi_bits(32'hA5, 8, 1'b0, rx);
    chk("bad_miso8", {32'd0, rx}, 64'd0);
    spi_stop();
    chk("bad_err_total", cmd_err_cnt - base, 64'd1);
    chk("bad_sb", sb.size(), 64'd0);

    // Reset during ADDR with chip select held low.
    base = cmd_err_cnt;
    spi_start();
    spi_bits(32'h03, 8, 1'b0, rx);
    spi_bits(32'h00, 8, 1'b0, rx);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_addr", {42'd0, bus.mem_addr}, 64'd0);
    chk("mid_rst_wdata", {32'd0, bus.mem_wdata}, 64'd0);
    chk("mid_rst_req", {63'd0, bus.mem_req}, 64'd0);
    rst = 1'b0;
    spi_bits(32'h0010, 16, 1'b0, rx);
    spi_bits(32'h0, 32, 1'b0, rx);
    chk("post_rst_miso", {32'd0, rx}, 64'd0);
    chk("post_rst_busy", {63'd0, busy}, 64'd0);
    spi_stop();
    mem[16] = 32'hCAFEF00D;
    push_acc(1'b0, 22'd16, 32'd0);
    spi_start();
    spi_bits(32'h03, 8, 1'b0, rx);
    spi_bits(32'h000040, 24, 1'b0, rx);
    spi_bits(32'h0, 32, 1'b1, rx);
    chk("post_rst_rd", {32'd0, rx}, {32'd0, 32'hCAFEF00D});
    repeat (4 * HALF) @(negedge clk);
    chk("post_rst_sb", sb.size(), 64'd0);
    chk("post_rst_err", cmd_err_cnt - base, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
